// File: rtl/me_anim_pkg.sv
// Player sprite animation: shared state codes, table entry type and lookup.
package me_anim_pkg;

  localparam int ANIM_HOLD_W = 4;

  localparam logic [7:0] ST_IDLE = 8'h01;
  localparam logic [7:0] ST_WALK = 8'h02;
  localparam logic [7:0] ST_JUMP = 8'h03;
  localparam logic [7:0] ST_ATK1 = 8'h05;
  localparam logic [7:0] ST_ATK2 = 8'h06;
  localparam logic [7:0] ST_ATK3 = 8'h07;
  localparam logic [7:0] ST_ATK4 = 8'h08;
  localparam logic [7:0] ST_ATK5 = 8'h09;

  typedef struct packed {
    logic [4:0]             base;
    logic [2:0]             count;
    logic [ANIM_HOLD_W-1:0] hold;
    logic                   oneshot;
  } anim_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_PLAY,
    S_DONE
  } anim_st_e;

  function automatic anim_t anim_lookup(input logic [7:0] code);
    anim_t a;
    unique case (1'b1)
      code == ST_IDLE: a = '{5'd0,  3'd4, 4'd8,  1'b0};
      code == ST_WALK: a = '{5'd4,  3'd4, 4'd8,  1'b0};
      code == ST_JUMP: a = '{5'd8,  3'd2, 4'd12, 1'b0};
      code == ST_ATK1: a = '{5'd10, 3'd3, 4'd5,  1'b1};
      code == ST_ATK2: a = '{5'd13, 3'd3, 4'd5,  1'b1};
      code == ST_ATK3: a = '{5'd16, 3'd4, 4'd4,  1'b1};
      code == ST_ATK4: a = '{5'd20, 3'd4, 4'd4,  1'b1};
      code == ST_ATK5: a = '{5'd24, 3'd6, 4'd4,  1'b1};
      default:         a = '{5'd0,  3'd1, 4'd1,  1'b0};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/me_anim_player_sync_edge_detect.sv
// Two-flop synchronizer (idle-high) followed by a registered rising-edge pulse.
module sync_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d_i,
  output logic pulse_o
);

  logic s1_q, s2_q, prev_q, pulse_q;

  // Flops reset high so a level already high at release is not an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= d_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pulse_q <= s2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/me_anim_player.sv
// Sprite animation sequencer: steps per-state sprite frames on vsync ticks
// and reports completion of one-shot (attack) animations.
module me_anim_player
  import me_anim_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] state_code,
  output logic [4:0] frame_idx,
  output logic       anim_done,
  output logic       busy
);

  logic tick;

  sync_edge_detect u_sync (
    .Clk     (Clk),
    .Reset   (Reset),
    .d_i     (frame_clk),
    .pulse_o (tick)
  );

  anim_st_e          state_q, state_d;
  logic [7:0]        cur_code_q, cur_code_d;
  logic [2:0]        offs_q, offs_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [4:0]        frame_idx_q, frame_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  anim_t ent_cur, ent_new, ent_nxt;
  logic  hold_last, offs_last, restart;
  logic  unused_fields;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_WAIT;
      cur_code_q  <= 8'h00;
      offs_q      <= 3'd0;
      hold_q      <= '0;
      frame_idx_q <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_code_q  <= cur_code_d;
      offs_q      <= offs_d;
      hold_q      <= hold_d;
      frame_idx_q <= frame_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    ent_cur   = anim_lookup(cur_code_q);
    ent_new   = anim_lookup(state_code);
    hold_last = hold_q == HOLD_W'(ent_cur.hold - 4'd1);
    offs_last = offs_q == (ent_cur.count - 3'd1);
    // A code change outranks any hold/advance decision on the same tick.
    restart   = (state_q == S_WAIT) || (state_code != cur_code_q);
  end

  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    offs_d     = offs_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (tick) begin
      if (restart) begin
        cur_code_d = state_code;
        offs_d     = 3'd0;
        hold_d     = '0;
        busy_d     = ent_new.oneshot;
        state_d    = S_PLAY;
      end else if (state_q == S_PLAY) begin
        if (!hold_last) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          if (!offs_last) begin
            offs_d = offs_q + 3'd1;
          end else if (!ent_cur.oneshot) begin
            offs_d = 3'd0;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
    end
  end

  always_comb begin
    ent_nxt     = anim_lookup(cur_code_d);
    frame_idx_d = ent_nxt.base + {2'b00, offs_d};
  end

  assign unused_fields = ^{ent_cur.base, ent_new.base, ent_new.count,
                           ent_new.hold, ent_nxt.count, ent_nxt.hold,
                           ent_nxt.oneshot};

  assign frame_idx = frame_idx_q;
  assign anim_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_me_anim_player.sv
// Directed self-checking bench for me_anim_player.
module tb_me_anim_player;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b1;
  logic [7:0] state_code = 8'h05;
  logic [4:0] frame_idx;
  logic       anim_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  me_anim_player #(.HOLD_W(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .state_code (state_code),
    .frame_idx  (frame_idx),
    .anim_done  (anim_done),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    if (anim_done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full vsync period; returns #1 after the edge where outputs react.
  task automatic frame_tick();
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
  endtask

  initial begin
    // Reset release with frame_clk high must not tick.
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("rst_frame", frame_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", anim_done, 0);

    // Looping idle animation.
    state_code = 8'h01;
    done_base  = done_cnt;
    frame_tick();
    check("idle_entry", frame_idx, 0);
    for (int k = 1; k <= 40; k++) begin
      frame_tick();
      check($sformatf("idle_k%0d", k), frame_idx, (k / 8) % 4);
    end
    check("idle_busy", busy, 0);
    check("idle_nodone", done_cnt - done_base, 0);

    // One-shot attack 05.
    state_code = 8'h05;
    done_base  = done_cnt;
    frame_tick();
    check("atk1_entry", frame_idx, 10);
    check("atk1_busy0", busy, 1);
    for (int k = 1; k <= 14; k++) begin
      frame_tick();
      check($sformatf("atk1_k%0d", k), frame_idx, 10 + k / 5);
      check($sformatf("atk1_busy_k%0d", k), busy, 1);
      check($sformatf("atk1_done_k%0d", k), anim_done, 0);
    end
    frame_tick();
    check("atk1_done15", anim_done, 1);
    check("atk1_busy15", busy, 0);
    check("atk1_last15", frame_idx, 12);
    @(posedge Clk);
    #1;
    check("atk1_done_1cyc", anim_done, 0);
    for (int k = 0; k < 6; k++) frame_tick();
    check("atk1_hold", frame_idx, 12);
    check("atk1_busy_end", busy, 0);
    check("atk1_done_once", done_cnt - done_base, 1);

    // 07 interrupted by 08 on tick 6.
    state_code = 8'h07;
    done_base  = done_cnt;
    frame_tick();
    check("atk3_entry", frame_idx, 16);
    for (int k = 1; k <= 5; k++) frame_tick();
    check("atk3_k5", frame_idx, 17);
    state_code = 8'h08;
    frame_tick();
    check("atk4_entry", frame_idx, 20);
    check("atk4_busy", busy, 1);
    for (int k = 1; k <= 3; k++) frame_tick();
    check("atk4_k3", frame_idx, 20);
    frame_tick();
    check("atk4_k4", frame_idx, 21);
    check("atk3_nodone", done_cnt - done_base, 0);

    // Reset in the middle of 09.
    state_code = 8'h09;
    frame_tick();
    check("atk5_entry", frame_idx, 24);
    for (int k = 1; k <= 10; k++) frame_tick();
    check("atk5_k10", frame_idx, 26);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("mid_rst_frame", frame_idx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", anim_done, 0);
    @(negedge Clk) Reset = 1'b0;
    frame_tick();
    check("post_rst_entry", frame_idx, 24);
    check("post_rst_busy", busy, 1);

    // Unknown code is a static frame 0.
    state_code = 8'h04;
    done_base  = done_cnt;
    frame_tick();
    check("unk_entry", frame_idx, 0);
    check("unk_busy0", busy, 0);
    for (int k = 1; k <= 20; k++) begin
      frame_tick();
      check($sformatf("unk_k%0d", k), frame_idx, 0);
    end
    check("unk_busy", busy, 0);
    check("unk_nodone", done_cnt - done_base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
